// File: rtl/spi_slave_shift_if.sv
// spi_slave_shift_if: tx buffer and rx character valid/ready streams of the SPI slave
interface spi_slave_shift_if #(
  parameter int MAX_CHAR = 32
);
  logic [MAX_CHAR-1:0] tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic [MAX_CHAR-1:0] rx_data;
  logic                rx_valid;
  logic                rx_ready;
  modport slave (input tx_data, tx_valid, rx_ready, output tx_ready, rx_data, rx_valid);
  modport master (output tx_data, tx_valid, rx_ready, input tx_ready, rx_data, rx_valid);
endinterface

// File: rtl/spi_slave_shift.sv
// spi_slave_shift: oversampled SPI slave shift engine, all CPOL/CPHA modes; define SPI_SLAVE_SYNC_EN for a two-flop input synchronizer
module spi_slave_shift #(
  parameter int MAX_CHAR = 32,
  parameter int LEN_BITS = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LEN_BITS-1:0] len,
  input  logic                cpol,
  input  logic                cpha,
  input  logic                lsb,
  input  logic                err_clr,
  output logic                ovr,
  output logic                udr,
  output logic                tip,
  input  logic                ss_n,
  input  logic                sclk,
  input  logic                mosi,
  output logic                miso,
  output logic                miso_oe,
  spi_slave_shift_if.slave    bus
);
  localparam int CW = LEN_BITS + 1;
  localparam logic [2:0] P_RST = 3'b100;
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q, state_d;
  logic [2:0] p;
  logic sclk_d, cpol_l, cpha_l, lsb_l;
  logic [CW-1:0] n_l, n_in, cnt, cnt_inc;
  logic [MAX_CHAR-1:0] tx_buf, tx_sh, rx_sh, rx_next;
  logic start, stop, smp, shf, done, reload, lead, trail, tx_load;

  function automatic logic [LEN_BITS-1:0] pos(input logic [CW-1:0] i, input logic [CW-1:0] n, input logic l);
    return LEN_BITS'(l ? i : n - CW'(1) - i);
  endfunction

`ifdef SPI_SLAVE_SYNC_EN
  logic [2:0] s1, s2;
  // two-flop synchronizer ahead of the common pipeline register {ss_n, sclk, mosi}
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1 <= P_RST;
      s2 <= P_RST;
      p  <= P_RST;
    end else begin
      s1 <= {ss_n, sclk, mosi};
      s2 <= s1;
      p  <= s2;
    end
`else
  // single pipeline register {ss_n, sclk, mosi}; inputs are already synchronous to clk
  always_ff @(posedge clk or negedge rst)
    if (!rst) p <= P_RST;
    else p <= {ss_n, sclk, mosi};
`endif

  // edge classification, transfer events and next state
  always_comb begin
    n_in = (len == '0) ? CW'(MAX_CHAR) : CW'(len) + CW'(1);
    lead = (p[1] ^ sclk_d) && (p[1] != cpol_l);
    trail = (p[1] ^ sclk_d) && (p[1] == cpol_l);
    start = (state_q == IDLE) && !p[2];
    stop = (state_q == ACTIVE) && p[2];
    smp = (state_q == ACTIVE) && !p[2] && (cpha_l ? trail : lead);
    shf = (state_q == ACTIVE) && !p[2] && (cpha_l ? lead : trail);
    cnt_inc = cnt + CW'(1);
    done = smp && (cnt_inc == n_l);
    reload = start || done;
    tx_load = bus.tx_valid && bus.tx_ready;
    rx_next = rx_sh;
    rx_next[pos(cnt, n_l, lsb_l)] = p[0];
    state_d = start ? ACTIVE : stop ? IDLE : state_q;
  end

  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else state_q <= state_d;

  // tx buffer, shift registers, rx output and sticky error flags
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sclk_d       <= 1'b0;
      cpol_l       <= 1'b0;
      cpha_l       <= 1'b0;
      lsb_l        <= 1'b0;
      n_l          <= '0;
      cnt          <= '0;
      tx_buf       <= '0;
      tx_sh        <= '0;
      rx_sh        <= '0;
      bus.tx_ready <= 1'b1;
      bus.rx_valid <= 1'b0;
      bus.rx_data  <= '0;
      ovr          <= 1'b0;
      udr          <= 1'b0;
      miso         <= 1'b0;
    end else begin
      sclk_d <= p[1];
      if (tx_load) tx_buf <= bus.tx_data;
      bus.tx_ready <= tx_load ? 1'b0 : reload ? 1'b1 : bus.tx_ready;
      if (reload) tx_sh <= bus.tx_ready ? '0 : tx_buf;
      udr <= (reload && bus.tx_ready) ? 1'b1 : err_clr ? 1'b0 : udr;
      if (start) begin
        cpol_l <= cpol;
        cpha_l <= cpha;
        lsb_l  <= lsb;
        n_l    <= n_in;
        cnt    <= '0;
        rx_sh  <= '0;
      end
      if (smp) begin
        cnt   <= done ? '0 : cnt_inc;
        rx_sh <= done ? '0 : rx_next;
      end
      if (done && (!bus.rx_valid || bus.rx_ready)) bus.rx_data <= rx_next;
      bus.rx_valid <= done ? 1'b1 : bus.rx_ready ? 1'b0 : bus.rx_valid;
      ovr <= (done && bus.rx_valid && !bus.rx_ready) ? 1'b1 : err_clr ? 1'b0 : ovr;
      miso <= start ? (!cpha && !bus.tx_ready && tx_buf[pos(CW'(0), n_in, lsb)])
            : stop ? 1'b0
            : shf ? tx_sh[pos(cnt, n_l, lsb_l)]
            : miso;
    end

  assign tip = (state_q == ACTIVE);
  assign miso_oe = tip;
endmodule

// File: tb/tb_spi_slave_shift.sv
// tb_spi_slave_shift: randomized scoreboard bench driving a behavioural SPI master against spi_slave_shift
module tb_spi_slave_shift;
`ifdef SPI_SLAVE_SYNC_EN
  localparam int L = 3;
`else
  localparam int L = 1;
`endif
  localparam int H = 6;
  logic clk = 0, rst = 0;
  logic [4:0] len = 0;
  logic cpol = 0, cpha = 0, lsb = 0, err_clr = 0, ss_n = 1, sclk = 0, mosi = 0;
  logic ovr, udr, tip, miso, miso_oe;
  int errors = 0, checks = 0;
  logic [31:0] exp_q[$];

  spi_slave_shift_if #(.MAX_CHAR(32)) bus();

  spi_slave_shift #(.MAX_CHAR(32), .LEN_BITS(5)) dut (
    .clk(clk), .rst(rst), .len(len), .cpol(cpol), .cpha(cpha), .lsb(lsb),
    .err_clr(err_clr), .ovr(ovr), .udr(udr), .tip(tip),
    .ss_n(ss_n), .sclk(sclk), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst && bus.rx_valid && bus.rx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got %h expected none", bus.rx_data);
      end else chk("rx_data", bus.rx_data, exp_q.pop_front());
    end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int li(input int i, input int n);
    return lsb ? i : n - 1 - i;
  endfunction

  function automatic logic [31:0] msk(input int n);
    return (n == 32) ? 32'hFFFF_FFFF : (32'h1 << n) - 32'h1;
  endfunction

  task automatic cfg(input logic p, input logic h, input logic l, input logic [4:0] ln);
    cpol = p;
    cpha = h;
    lsb = l;
    len = ln;
    sclk = p;
    tick(6);
  endtask

  task automatic push_tx(input logic [31:0] w);
    int t = 0;
    while (!bus.tx_ready && t < 50) begin
      tick(1);
      t++;
    end
    chk("tx_ready_wait", {31'b0, bus.tx_ready}, 32'd1);
    bus.tx_data = w;
    bus.tx_valid = 1;
    tick(1);
    bus.tx_valid = 0;
    chk("tx_ready_fall", {31'b0, bus.tx_ready}, 32'd0);
  endtask

  task automatic ss_lo();
    ss_n = 0;
    tick(8);
  endtask

  task automatic ss_hi();
    tick(2);
    ss_n = 1;
    tick(8);
  endtask

  task automatic half(input bit lat);
    for (int k = 1; k <= H; k++) begin
      tick(1);
      if (lat && k == L) chk("rx_valid_early", {31'b0, bus.rx_valid}, 32'd0);
      if (lat && k == L + 1) chk("rx_valid_rise", {31'b0, bus.rx_valid}, 32'd1);
    end
  endtask

  task automatic char(input int n, input int nsend, input logic [31:0] w, input bit lat, output logic [31:0] got);
    got = 0;
    mosi = w[li(0, n)];
    tick(2);
    for (int i = 0; i < nsend; i++) begin
      if (cpha) begin
        sclk = ~cpol;
        mosi = w[li(i, n)];
        tick(H);
        got[li(i, n)] = miso;
        sclk = cpol;
        half(lat && i == n - 1);
      end else begin
        got[li(i, n)] = miso;
        sclk = ~cpol;
        half(lat && i == n - 1);
        sclk = cpol;
        if (i < n - 1) mosi = w[li(i + 1, n)];
        tick(H);
      end
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1;
    tick(1);
    err_clr = 0;
  endtask

  initial begin
    logic [31:0] got, got2, m;
    logic [31:0] t[2];
    int n, nch;
    bus.tx_valid = 0;
    bus.tx_data = 0;
    bus.rx_ready = 1;
    tick(3);
    chk("rst_tx_ready", {31'b0, bus.tx_ready}, 32'd1);
    chk("rst_rx_valid", {31'b0, bus.rx_valid}, 32'd0);
    chk("rst_rx_data", bus.rx_data, 32'd0);
    chk("rst_flags", {27'b0, ovr, udr, tip, miso, miso_oe}, 32'd0);
    rst = 1;
    tick(6);

    cfg(0, 0, 0, 5'd7);
    push_tx(32'hA5);
    ss_lo();
    chk("m0_tip", {30'b0, tip, miso_oe}, 32'd3);
    chk("m0_first_miso", {31'b0, miso}, 32'd1);
    chk("m0_tx_ready", {31'b0, bus.tx_ready}, 32'd1);
    exp_q.push_back(32'h3C);
    char(8, 8, 32'h3C, 1, got);
    chk("m0_miso_word", got, 32'hA5);
    ss_hi();
    chk("m0_idle", {30'b0, tip, miso_oe}, 32'd0);

    cfg(1, 1, 1, 5'd0);
    push_tx(32'hDEADBEEF);
    ss_lo();
    exp_q.push_back(32'h12345678);
    char(32, 32, 32'h12345678, 0, got);
    chk("m3_miso_word", got, 32'hDEADBEEF);
    ss_hi();

    bus.rx_ready = 0;
    pulse_clr();
    cfg(0, 0, 0, 5'd7);
    push_tx(32'h11);
    ss_lo();
    push_tx(32'h22);
    exp_q.push_back(32'hC1);
    char(8, 8, 32'hC1, 0, got);
    char(8, 8, 32'hC2, 0, got2);
    ss_hi();
    chk("ovr_miso1", got, 32'h11);
    chk("ovr_miso2", got2, 32'h22);
    chk("ovr_rx_kept", bus.rx_data, 32'hC1);
    chk("ovr_rx_valid", {31'b0, bus.rx_valid}, 32'd1);
    chk("ovr_set", {31'b0, ovr}, 32'd1);
    pulse_clr();
    chk("ovr_clr", {31'b0, ovr}, 32'd0);
    bus.rx_ready = 1;
    tick(3);
    chk("ovr_drained", {31'b0, bus.rx_valid}, 32'd0);

    cfg(0, 1, 0, 5'd15);
    chk("udr_pre", {31'b0, udr}, 32'd0);
    ss_lo();
    chk("udr_set", {31'b0, udr}, 32'd1);
    chk("udr_tx_ready", {31'b0, bus.tx_ready}, 32'd1);
    m = $urandom;
    exp_q.push_back(m & 32'hFFFF);
    char(16, 16, m, 0, got);
    ss_hi();
    chk("udr_miso_zero", got, 32'd0);
    chk("udr_tx_ready_end", {31'b0, bus.tx_ready}, 32'd1);
    pulse_clr();

    cfg(0, 0, 0, 5'd7);
    push_tx(32'h5A);
    ss_lo();
    char(8, 5, $urandom, 0, got);
    ss_hi();
    chk("abort_miso_part", got & 32'hF8, 32'h58);
    chk("abort_idle", {29'b0, tip, miso_oe, miso}, 32'd0);
    chk("abort_no_rx", {31'b0, bus.rx_valid}, 32'd0);
    push_tx(32'hC3);
    ss_lo();
    m = $urandom;
    exp_q.push_back(m & 32'hFF);
    char(8, 8, m, 0, got);
    ss_hi();
    chk("abort_next_miso", got, 32'hC3);

    for (int r = 0; r < 20; r++) begin
      cfg(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 31)));
      n = (len == 0) ? 32 : int'(len) + 1;
      nch = $urandom_range(1, 2);
      t[0] = $urandom;
      t[1] = $urandom;
      push_tx(t[0]);
      ss_lo();
      if (nch == 2) push_tx(t[1]);
      for (int c = 0; c < nch; c++) begin
        m = $urandom;
        exp_q.push_back(m & msk(n));
        char(n, n, m, 0, got);
        chk("rand_miso_word", got, t[c] & msk(n));
      end
      ss_hi();
    end

    pulse_clr();
    cfg(0, 0, 0, 5'd7);
    ss_lo();
    char(8, 3, $urandom, 0, got);
    chk("mid_active", {30'b0, tip, udr}, 32'd3);
    #2 rst = 0;
    #1;
    chk("arst_flags", {27'b0, ovr, udr, tip, miso, miso_oe}, 32'd0);
    chk("arst_tx_ready", {31'b0, bus.tx_ready}, 32'd1);
    chk("arst_rx", {31'b0, bus.rx_valid}, 32'd0);
    chk("arst_rx_data", bus.rx_data, 32'd0);
    ss_n = 1;
    tick(2);
    rst = 1;
    tick(6);
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
